// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux_sel_pipe select stage.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: clog2 constant function, default WIDTH/NUM_IN, beat struct for the
// default configuration, and the skid buffer occupancy state type.
package mux_sel_pkg;

    localparam int DEF_WIDTH  = 5;
    localparam int DEF_NUM_IN = 4;

    // Number of bits needed to index n items (n >= 2 gives >= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // One beat of the default configuration: selected data, the select that
    // produced it, and the out-of-range flag.
    typedef struct packed {
        logic [DEF_WIDTH-1:0]         data;
        logic [clog2(DEF_NUM_IN)-1:0] sel;
        logic                         err;
    } beat_t;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // main invalid
        ST_ONE   = 2'd1,   // main valid, skid empty
        ST_FULL  = 2'd2    // main and skid valid, upstream stalled
    } skid_state_e;

endpackage

// File: rtl/mux_sel_pipe_skid_reg.sv
// Generic two-entry valid/ready skid buffer over a W-bit payload.
// Latency: 1 cycle from in_fire to out_valid when main is empty or draining.
// Backpressure: in_ready is a register (low only when both entries are full);
//   there is no combinational path from out_ready to in_ready.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_dat upstream;
//   out_valid/out_ready/out_dat downstream (out_dat driven by the main register).
module skid_reg
    import mux_sel_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_dat
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         in_fire, out_fire;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_dat   = main_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_dat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_dat;
                end else if (in_fire) begin
                    skid_d  = in_dat;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Ready for next cycle is decided from the next occupancy, which keeps
        // the output-side handshake off the combinational ready path.
        in_ready_d = (state_d != ST_FULL);
    end

    // in_ready resets low so nothing is accepted while reset is held; it
    // rises on the first clock edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Parametrised N:1 select stage with registered output behind a skid buffer.
// Latency: 1 cycle from in_fire to out_valid when the output is empty or draining.
// Backpressure: full throughput under stall via 2-entry skid; in_ready registered.
// Ports: clk, reset (async, active high); in_valid/in_ready, sel, data_in
//   (input i at [i*WIDTH +: WIDTH]); out_valid/out_ready, out_data, out_sel.
// Optional macro MUX_SEL_PIPE_ERR_EN adds out_err (per beat, sel >= NUM_IN)
//   and err_sticky (set on any accepted out-of-range sel, cleared by reset).
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel
`ifdef MUX_SEL_PIPE_ERR_EN
    ,
    output logic                    out_err,
    output logic                    err_sticky
`endif
);

    // Beat type sized for this instance; main and skid entries both hold it.
`ifdef MUX_SEL_PIPE_ERR_EN
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } sel_beat_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
    } sel_beat_t;
`endif

    logic [WIDTH-1:0] sel_data;
    sel_beat_t        in_beat;
    sel_beat_t        out_beat;

    // Selection happens at capture. An out-of-range select matches no input
    // and so leaves the zero default in place.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                sel_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_beat.data = sel_data;
    assign in_beat.sel  = sel;

`ifdef MUX_SEL_PIPE_ERR_EN
    logic sel_oor;
    logic err_sticky_q, err_sticky_d;

    assign sel_oor     = (int'(sel) >= NUM_IN);
    assign in_beat.err = sel_oor;

    assign err_sticky_d = err_sticky_q | (in_valid & in_ready & sel_oor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign out_err    = out_beat.err;
`endif

    skid_reg #(
        .W($bits(sel_beat_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_beat)
    );

    assign out_data = out_beat.data;
    assign out_sel  = out_beat.sel;

endmodule
